// File: rtl/rng_word_feeder_if.sv
// Handshake bundle between the PRNG source, the word feeder and the Gaussian sampler.
// master = feeder side (drives src_ready / rng_valid / rng); slave = source+sampler side.
interface rng_word_feeder_if;
    logic         src_valid;
    logic [63:0]  src_data;
    logic         src_ready;
    logic         rng_valid;
    logic [127:0] rng;
    logic         rng_extract;

    modport master (
        input  src_valid,
        input  src_data,
        output src_ready,
        output rng_valid,
        output rng,
        input  rng_extract
    );

    modport slave (
        output src_valid,
        output src_data,
        input  src_ready,
        input  rng_valid,
        input  rng,
        output rng_extract
    );
endinterface

// File: rtl/rng_word_feeder.sv
// Packs pairs of 64-bit PRNG words into 128-bit random words and buffers them for the sampler.
// Optional feature macro: RNG_STAT_EN adds the saturating delivered-word counter o_rng_count.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | disabled; FIFO and half-word register held flushed, src_ready=0
// S_RUN  | accepting, packing and presenting words
module rng_word_feeder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ena,
    rng_word_feeder_if.master   bus
`ifdef RNG_STAT_EN
    ,
    output logic [31:0]         o_rng_count
`endif
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_half_full;
    logic [63:0]        r_half_lo;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [127:0]       r_mem [DEPTH];

    logic               w_src_ready;
    logic               w_flush;
    logic               w_rng_valid;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // src_ready only looks at ena and registered state, never at rng_extract.
    always_comb begin
        w_state_nxt = r_state;
        w_src_ready = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_flush = 1'b1;
                if (i_ena) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_ena) begin
                    w_state_nxt = S_IDLE;
                    w_flush     = 1'b1;
                end else begin
                    w_src_ready = !r_half_full || (r_count < DEPTH_C);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    assign w_rng_valid = (r_count != '0);
    assign w_pop       = w_rng_valid && bus.rng_extract;
    assign w_accept    = w_src_ready && bus.src_valid;
    assign w_push      = w_accept && r_half_full && (r_count != DEPTH_C);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_half_full <= 1'b0;
            r_half_lo   <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else if (w_flush) begin
            // Any pending half word is dropped along with the buffered entries.
            r_half_full <= 1'b0;
            r_half_lo   <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_accept && !r_half_full) begin
                r_half_lo   <= bus.src_data;
                r_half_full <= 1'b1;
            end
            if (w_push) begin
                r_half_full <= 1'b0;
                r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the output mux forces rng to zero while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.src_data, r_half_lo};
        end
    end

    assign bus.src_ready = w_src_ready;
    assign bus.rng_valid = w_rng_valid;
    assign bus.rng       = w_rng_valid ? r_mem[r_rd_ptr] : '0;

`ifdef RNG_STAT_EN
    logic [31:0] r_rng_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rng_count <= '0;
        end else if (w_pop && (r_rng_count != 32'hFFFF_FFFF)) begin
            r_rng_count <= r_rng_count + 32'd1;
        end
    end

    assign o_rng_count = r_rng_count;
`endif

endmodule
